systolic_ctrl: RTL

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

---
 rtl/tpu_pkg.sv | 15 +
 rtl/skew_window.sv | 18 +
 rtl/systolic_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared constants for the TPU control blocks: default array geometry and
// the systolic controller state encoding.
package tpu_pkg;

  localparam int TPU_N       = 4;
  localparam int TPU_K_WIDTH = 8;

  localparam int ST_WIDTH = 3;
  localparam logic [ST_WIDTH-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_WIDTH-1:0] ST_CLEAR = 3'd1;
  localparam logic [ST_WIDTH-1:0] ST_FEED  = 3'd2;
  localparam logic [ST_WIDTH-1:0] ST_DRAIN = 3'd3;
  localparam logic [ST_WIDTH-1:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/skew_window.sv
// Per-lane fetch window: lane i is active while 0 <= step-i < K, which
// staggers the operand stream one cycle per row/column.
module skew_window #(
  parameter int N       = 4,
  parameter int K_WIDTH = 8,
  parameter int S_WIDTH = K_WIDTH + 2
) (
  input  logic [S_WIDTH-1:0] step,
  input  logic [K_WIDTH-1:0] k,
  output logic [N-1:0]       en
);

  for (genvar i = 0; i < N; i++) begin : g_lane
    localparam logic [S_WIDTH-1:0] IDX = S_WIDTH'(i);
    assign en[i] = (step >= IDX) && (step < IDX + S_WIDTH'(k));
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for one N x N systolic matrix-multiply pass: clear, skewed feed,
// drain, done. Every output is a flop loaded from the next-state decode.
module systolic_ctrl
  import tpu_pkg::*;
#(
  parameter int N       = TPU_N,
  parameter int K_WIDTH = TPU_K_WIDTH,
  parameter int S_WIDTH = K_WIDTH + 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [K_WIDTH-1:0]  k_len,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                acc_clr,
  output logic                pe_en,
  output logic [N-1:0]        a_rd_en,
  output logic [N-1:0]        b_rd_en,
  output logic [S_WIDTH-1:0]  step,
  output logic [ST_WIDTH-1:0] state_dbg
);

  localparam int D_WIDTH = (N > 2) ? $clog2(N - 1) : 1;
  localparam logic [S_WIDTH-1:0] FEED_TAIL  = S_WIDTH'(N - 2);
  localparam logic [D_WIDTH-1:0] DRAIN_LAST = D_WIDTH'(N - 2);

  logic [ST_WIDTH-1:0] state_q, state_d;
  logic [S_WIDTH-1:0]  step_q, step_d;
  logic [K_WIDTH-1:0]  k_q, k_d;
  logic [D_WIDTH-1:0]  dcnt_q, dcnt_d;
  logic                zdly_q, zdly_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                acc_clr_q, acc_clr_d;
  logic                pe_en_q, pe_en_d;
  logic [N-1:0]        a_rd_en_q, a_rd_en_d;
  logic [N-1:0]        b_rd_en_q, b_rd_en_d;
  logic [N-1:0]        a_win, b_win;
  logic [S_WIDTH-1:0]  feed_last;

  assign feed_last = S_WIDTH'(k_q) + FEED_TAIL;

  // A K=0 request parks one extra cycle in DONE (zdly) so done lands in cycle 2.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    k_d     = k_q;
    dcnt_d  = dcnt_q;
    zdly_d  = zdly_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          k_d = k_len;
          if (k_len != '0) begin
            state_d = ST_CLEAR;
          end else begin
            state_d = ST_DONE;
            zdly_d  = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FEED;
          step_d  = '0;
        end
      end
      ST_FEED: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (step_q == feed_last) begin
          state_d = ST_DRAIN;
          dcnt_d  = '0;
        end else begin
          step_d = step_q + S_WIDTH'(1);
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (dcnt_q == DRAIN_LAST) begin
          state_d = ST_DONE;
        end else begin
          dcnt_d = dcnt_q + D_WIDTH'(1);
        end
      end
      ST_DONE: begin
        if (zdly_q) begin
          zdly_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  skew_window #(.N(N), .K_WIDTH(K_WIDTH), .S_WIDTH(S_WIDTH)) u_win_a (
    .step (step_d),
    .k    (k_d),
    .en   (a_win)
  );

  skew_window #(.N(N), .K_WIDTH(K_WIDTH), .S_WIDTH(S_WIDTH)) u_win_b (
    .step (step_d),
    .k    (k_d),
    .en   (b_win)
  );

  always_comb begin
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE) && !zdly_d;
    acc_clr_d = (state_d == ST_CLEAR);
    pe_en_d   = (state_d == ST_FEED) || (state_d == ST_DRAIN);
    a_rd_en_d = (state_d == ST_FEED) ? a_win : '0;
    b_rd_en_d = (state_d == ST_FEED) ? b_win : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      step_q    <= '0;
      k_q       <= '0;
      dcnt_q    <= '0;
      zdly_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      acc_clr_q <= 1'b0;
      pe_en_q   <= 1'b0;
      a_rd_en_q <= '0;
      b_rd_en_q <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      k_q       <= k_d;
      dcnt_q    <= dcnt_d;
      zdly_q    <= zdly_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      acc_clr_q <= acc_clr_d;
      pe_en_q   <= pe_en_d;
      a_rd_en_q <= a_rd_en_d;
      b_rd_en_q <= b_rd_en_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign acc_clr   = acc_clr_q;
  assign pe_en     = pe_en_q;
  assign a_rd_en   = a_rd_en_q;
  assign b_rd_en   = b_rd_en_q;
  assign step      = step_q;
  assign state_dbg = state_q;

endmodule
